// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the systolic array datapath.
package tpu_pkg;

    localparam int BITS_C_DEF = 16;
    localparam int DIM_DEF    = 8;

    typedef logic signed [BITS_C_DEF-1:0] elem_t;
    typedef elem_t [DIM_DEF-1:0]          row_t;

endpackage

// File: rtl/memc_delay_lane.sv
// Fixed-latency register delay line for one array output lane; LAT=0 is a wire.
module memc_delay_lane #(
    parameter int BITS_C = 16,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BITS_C-1:0] d,
    output logic [BITS_C-1:0] q
);

    generate
        if (LAT == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [BITS_C-1:0] stg [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < LAT; k++) stg[k] <= '0;
                end else begin
                    stg[0] <= d;
                    for (int unsigned k = 1; k < LAT; k++) stg[k] <= stg[k-1];
                end
            end

            assign q = stg[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/memc_deskew.sv
// Realigns diagonally skewed array result rows and buffers them in a row FIFO.
// Define MEMC_OVF_STICKY_EN for a sticky ovf flag; otherwise ovf pulses per dropped row.
module memc_deskew
    import tpu_pkg::*;
#(
    parameter int BITS_C = BITS_C_DEF,
    parameter int DIM    = DIM_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [DIM-1:0][BITS_C-1:0]   Cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIM-1:0][BITS_C-1:0]   Cout,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DIM-1:0][BITS_C-1:0] row_al;
    logic [DIM-2:0]             vpipe;
    logic                       row_v;

    // Lane i arrives i cycles late, so it gets DIM-1-i stages of delay.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        memc_delay_lane #(
            .BITS_C(BITS_C),
            .LAT   (DIM - 1 - i)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (Cin[i]),
            .q    (row_al[i])
        );
    end

    assign row_v = vpipe[DIM-2];

    logic [DIM-1:0][BITS_C-1:0] mem [DEPTH];
    logic [AW-1:0]              wptr;
    logic [AW-1:0]              rptr;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              count_nxt;
    logic                       out_valid_q;
    logic                       ovf_q;
    logic                       full;
    logic                       rd;
    logic                       wr;
    logic                       drop;

    assign full = (count_q == CW'(DEPTH));
    assign rd   = out_valid_q && out_ready;
    assign wr   = row_v && (!full || rd);
    assign drop = row_v && full && !rd;

    always_comb begin
        count_nxt = count_q;
        if (wr && !rd)
            count_nxt = count_q + 1'b1;
        else if (rd && !wr)
            count_nxt = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (clr) begin
            vpipe       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            vpipe[0] <= in_valid;
            for (int unsigned k = 1; k < DIM - 1; k++) vpipe[k] <= vpipe[k-1];
            // When full with a read, wptr==rptr: the head is consumed this edge and its slot refilled.
            if (wr) begin
                mem[wptr] <= row_al;
                wptr      <= wptr + 1'b1;
            end
            if (rd)
                rptr <= rptr + 1'b1;
            count_q     <= count_nxt;
            out_valid_q <= (count_nxt != '0);
`ifdef MEMC_OVF_STICKY_EN
            if (drop)
                ovf_q <= 1'b1;
`else
            ovf_q <= drop;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign Cout      = mem[rptr];

endmodule

// File: tb/tb_memc_deskew.sv
// Scoreboard bench for memc_deskew: stimulus queues expected rows, a monitor pops them on handshake.
module tb_memc_deskew;
    import tpu_pkg::*;

    localparam int DIM   = 8;
    localparam int BITSC = 16;
    localparam int DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       clr;
    logic                       in_valid;
    logic [DIM-1:0][BITSC-1:0]  cin;
    logic                       out_valid;
    logic                       out_ready;
    logic [DIM-1:0][BITSC-1:0]  cout;
    logic [$clog2(DEPTH):0]     count;
    logic                       ovf;

    memc_deskew #(.BITS_C(BITSC), .DIM(DIM), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .Cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Cout     (cout),
        .count    (count),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        row_t row;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    row_t hist [DIM];
    logic hv   [DIM];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic row_t mkrow(input int base);
        row_t r;
        for (int i = 0; i < DIM; i++) r[i] = 16'(base + i);
        return r;
    endfunction

    // One cycle of skewed drive: lane i carries the row issued i cycles ago.
    task automatic step(input logic iv, input row_t r);
        for (int k = DIM - 1; k > 0; k--) begin
            hist[k] = hist[k-1];
            hv[k]   = hv[k-1];
        end
        hist[0] = r;
        hv[0]   = iv;
        for (int i = 0; i < DIM; i++)
            cin[i] = hv[i] ? hist[i][i] : 16'(16'h5a00 + i);
        in_valid = iv;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input row_t r, input bit push, input bit timed);
        exp_t e;
        if (push) begin
            e.row = r;
            e.cyc = timed ? cyc + DIM : -1;
            q.push_back(e);
        end
        step(1'b1, r);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_row", cout, '0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("row_data", cout, e.row);
                if (e.cyc >= 0) chk("row_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int s;
        for (int k = 0; k < DIM; k++) begin
            hist[k] = '0;
            hv[k]   = 1'b0;
        end
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = '0;
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cout", cout, 0);
        idle(2);
        rst_n = 1'b1;

        // single row at cycle 10, expected out at cycle 18
        out_ready = 1'b1;
        while (cyc < 10) idle(1);
        issue(mkrow(1), 1'b1, 1'b1);
        idle(12);
        chk("single_count", count, 0);
        chk("single_out_valid", out_valid, 0);

        // 16 back-to-back rows
        for (int r = 0; r < 16; r++) issue(mkrow(16 * r), 1'b1, 1'b1);
        idle(12);
        chk("stream_ovf", ovf, 0);
        chk("stream_count", count, 0);

        // full FIFO with a read in the same cycle the 5th row aligns
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) issue(mkrow(16'h200 + 16'h10 * r), 1'b1, 1'b0);
        idle(6);
        chk("fullrw_pre_count", count, 4);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("fullrw_count", count, 4);
        chk("fullrw_ovf", ovf, 0);
        chk("fullrw_out_valid", out_valid, 1);
        out_ready = 1'b1;
        idle(8);
        chk("fullrw_drain_count", count, 0);

        // back-pressure, then a dropped 5th row
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) issue(mkrow(16'h300 + 16'h10 * r), 1'b1, 1'b0);
        idle(7);
        chk("bp_count", count, 4);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_cout_head", cout, mkrow(16'h300));
        issue(mkrow(16'h3f0), 1'b0, 1'b0);
        idle(7);
        chk("drop_ovf", ovf, 1);
        chk("drop_count", count, 4);
        idle(1);
`ifdef MEMC_OVF_STICKY_EN
        chk("ovf_after", ovf, 1);
`else
        chk("ovf_after", ovf, 0);
`endif
        chk("drop_cout_hold", cout, mkrow(16'h300));
        out_ready = 1'b1;
        idle(6);
        chk("bp_drain_count", count, 0);

        // clr with 2 buffered and 3 in flight
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) issue(mkrow(16'h400 + 16'h10 * r), 1'b1, 1'b0);
        idle(4);
        chk("clr_pre_count", count, 2);
        clr = 1'b1;
        q.delete();
        idle(1);
        clr = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_ovf", ovf, 0);
        out_ready = 1'b1;
        idle(12);
        chk("clr_post_count", count, 0);

        // asynchronous reset between edges
        out_ready = 1'b0;
        s = cyc;
        issue(mkrow(16'h500), 1'b1, 1'b0);
        issue(mkrow(16'h510), 1'b1, 1'b0);
        idle(10);
        chk("arst_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_cout", cout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(12);
        chk("arst_post_count", count, 0);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
